// File: rtl/axi_exit_ctrl_if.sv
// AXI4-Lite bus bundle for the exit-code controller.
// The slave modport is used by the controller; master by whatever drives it.
interface axi_exit_ctrl_if #(
  parameter int ADDR_WIDTH = 20
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_exit_ctrl.sv
// AXI4-Lite slave collecting sticky per-channel exit codes and reducing them
// to all-exited / any-failed flags for the board or simulation exit logic.
module axi_exit_ctrl #(
  parameter int ADDR_WIDTH = 20,
  parameter int N_CH       = 4
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  axi_exit_ctrl_if.slave      s_axi,
  output logic [N_CH-1:0]     exit_valid_o,
  output logic [N_CH-1:0]     exit_zero_o,
  output logic [32*N_CH-1:0]  exit_value_o,
  output logic                all_exited_o,
  output logic                any_fail_o
);
  localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  // Channel field covers the 16-channel maximum so unpopulated indices are
  // detected and answered with SLVERR instead of aliasing onto real channels.
  localparam int CH_FW = 4;
  localparam int DEC_W = 5 + CH_FW;

  localparam logic [4:0] OFF_STATUS = 5'h00;
  localparam logic [4:0] OFF_CODE   = 5'h04;
  localparam logic [4:0] OFF_VALUE  = 5'h08;
  localparam logic [4:0] OFF_OK     = 5'h10;
  localparam logic [4:0] OFF_CLEAR  = 5'h18;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic             aw_cap_q, w_cap_q;
  logic [DEC_W-1:0] awaddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [31:0]      rdata_q;

  logic [N_CH-1:0]  valid_q, zero_q;
  logic [31:0]      value_q [N_CH];

  logic             aw_hs, w_hs, b_hs, ar_hs, do_write, bvalid;
  logic [DEC_W-1:0] wr_addr;
  logic [31:0]      wr_data, wr_masked, rd_data;
  logic [3:0]       wr_strb;
  logic             wr_ch_ok, rd_ch_ok;
  logic [CHW-1:0]   wr_idx, rd_idx;

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[ADDR_WIDTH-1:DEC_W], s_axi.araddr[ADDR_WIDTH-1:DEC_W]};

  assign bvalid = (w_state_q == W_RESP);
  assign aw_hs  = s_axi.awvalid & s_axi.awready;
  assign w_hs   = s_axi.wvalid & s_axi.wready;
  assign b_hs   = bvalid & s_axi.bready;
  assign ar_hs  = s_axi.arvalid & s_axi.arready;

  // A beat handshaking this cycle counts as held, giving single-cycle latency.
  assign wr_addr  = aw_cap_q ? awaddr_q : s_axi.awaddr[DEC_W-1:0];
  assign wr_data  = w_cap_q ? wdata_q : s_axi.wdata;
  assign wr_strb  = w_cap_q ? wstrb_q : s_axi.wstrb;
  assign do_write = (w_state_q == W_IDLE) & (aw_cap_q | aw_hs) & (w_cap_q | w_hs);
  assign wr_ch_ok = (wr_addr[5 +: CH_FW] < N_CH);
  assign wr_idx   = wr_addr[5 +: CHW];
  assign rd_ch_ok = (s_axi.araddr[5 +: CH_FW] < N_CH);
  assign rd_idx   = s_axi.araddr[5 +: CHW];

  always_comb begin
    for (int b = 0; b < 4; b++) wr_masked[8*b +: 8] = wr_strb[b] ? wr_data[8*b +: 8] : 8'h00;
  end

  // ---------------- write FSM ----------------
  // NOTE: state and storage use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) w_state_q <= W_IDLE;
    else              w_state_q <= w_state_d;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (do_write)     w_state_d = W_RESP;
      W_RESP:  if (s_axi.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.bvalid  = bvalid;
    s_axi.bresp   = bresp_q;
    s_axi.awready = ~s_axi_areset & ~aw_cap_q & ~bvalid;
    s_axi.wready  = ~s_axi_areset & ~w_cap_q & ~bvalid;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      aw_cap_q <= 1'b0;
      w_cap_q  <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_cap_q <= 1'b1;
        awaddr_q <= s_axi.awaddr[DEC_W-1:0];
      end
      if (w_hs) begin
        w_cap_q <= 1'b1;
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (do_write) bresp_q <= wr_ch_ok ? RESP_OKAY : RESP_SLV;
      if (b_hs) begin
        aw_cap_q <= 1'b0;
        w_cap_q  <= 1'b0;
      end
    end
  end

  // ---------------- exit records ----------------
  // NOTE: the record array is reset explicitly; software relies on every channel starting disarmed.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      valid_q <= '0;
      zero_q  <= '0;
      for (int c = 0; c < N_CH; c++) value_q[c] <= '0;
    end else if (do_write && wr_ch_ok && (wr_strb != 4'h0)) begin
      case (wr_addr[4:0])
        OFF_CODE: if (!valid_q[wr_idx]) begin
          value_q[wr_idx] <= wr_masked;
          valid_q[wr_idx] <= 1'b1;
          zero_q[wr_idx]  <= (wr_masked == 32'h0);
        end
        OFF_OK: if (!valid_q[wr_idx]) begin
          value_q[wr_idx] <= '0;
          valid_q[wr_idx] <= 1'b1;
          zero_q[wr_idx]  <= 1'b1;
        end
        OFF_CLEAR: begin
          value_q[wr_idx] <= '0;
          valid_q[wr_idx] <= 1'b0;
          zero_q[wr_idx]  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) r_state_q <= R_IDLE;
    else              r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)        r_state_d = R_DATA;
      R_DATA:  if (s_axi.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = ~s_axi_areset & (r_state_q == R_IDLE);
    s_axi.rvalid  = (r_state_q == R_DATA);
    s_axi.rdata   = rdata_q;
    s_axi.rresp   = rresp_q;
  end

  always_comb begin
    rd_data = '0;
    if (rd_ch_ok) begin
      case (s_axi.araddr[4:0])
        OFF_STATUS: rd_data = {30'h0, zero_q[rd_idx], valid_q[rd_idx]};
        OFF_VALUE:  rd_data = value_q[rd_idx];
        default:    rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data;
      rresp_q <= rd_ch_ok ? RESP_OKAY : RESP_SLV;
    end
  end

  // ---------------- aggregated outputs ----------------
  always_comb begin
    exit_valid_o = valid_q;
    exit_zero_o  = zero_q;
    for (int c = 0; c < N_CH; c++) exit_value_o[32*c +: 32] = value_q[c];
    all_exited_o = &valid_q;
    any_fail_o   = |(valid_q & ~zero_q);
  end
endmodule

// File: tb/tb_axi_exit_ctrl.sv
// Directed bench for axi_exit_ctrl: write/read paths, sticky exits,
// out-of-range channels, handshake ordering and asynchronous reset.
module tb_axi_exit_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   exit_valid, exit_zero;
  logic [127:0] exit_value;
  logic         all_exited, any_fail;
  int           tests_run = 0;
  int           tests_failed = 0;

  always #5 clk = ~clk;

  axi_exit_ctrl_if #(.ADDR_WIDTH(20)) bus ();

  axi_exit_ctrl #(.ADDR_WIDTH(20), .N_CH(4)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .s_axi        (bus),
    .exit_valid_o (exit_valid),
    .exit_zero_o  (exit_zero),
    .exit_value_o (exit_value),
    .all_exited_o (all_exited),
    .any_fail_o   (any_fail)
  );

  // Called and returning on a falling edge; AW and W presented together.
  task automatic axi_write(input logic [19:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output bit on_time);
    int cyc = 0;
    bit aw_go, w_go;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data;  bus.wstrb = strb; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    while ((bus.awvalid || bus.wvalid) && cyc < 20) begin
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      @(negedge clk); cyc++;
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go)  bus.wvalid  = 1'b0;
    end
    on_time = !bus.awvalid && !bus.wvalid && (bus.bvalid === 1'b1);
    resp = bus.bresp;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [19:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit on_time);
    int cyc = 0;
    bit go = 1'b0;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
    while (!go && cyc < 20) begin
      go = bus.arready;
      @(negedge clk); cyc++;
    end
    bus.arvalid = 1'b0;
    on_time = go && (bus.rvalid === 1'b1);
    data = bus.rdata;
    resp = bus.rresp;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake: got %b expected 00000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    tests_run++;
    if ({exit_valid, exit_zero, all_exited, any_fail} !== 10'b0 || exit_value !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_exit_outputs: valid=%b zero=%b all=%b fail=%b value=%h",
               exit_valid, exit_zero, all_exited, any_fail, exit_value);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exit_zero();
    logic [1:0] resp; bit ok;
    axi_write(20'h00004, 32'h0, 4'hF, resp, ok);
    tests_run++;
    if (!ok || resp !== 2'b00) begin
      tests_failed++;
      $display("FAIL exit_zero_b: on_time=%0d bresp=%b expected on_time=1 bresp=00", ok, resp);
    end
    tests_run++;
    if (exit_valid !== 4'b0001 || exit_zero !== 4'b0001 || any_fail !== 1'b0) begin
      tests_failed++;
      $display("FAIL exit_zero_flags: valid=%b zero=%b fail=%b expected 0001 0001 0",
               exit_valid, exit_zero, any_fail);
    end
  endtask

  task automatic test_sticky();
    logic [1:0] resp; bit ok;
    axi_write(20'h00024, 32'hDEAD_BEEF, 4'h3, resp, ok);
    tests_run++;
    if (!ok || resp !== 2'b00 || exit_value[63:32] !== 32'h0000_BEEF) begin
      tests_failed++;
      $display("FAIL strobe_mask: on_time=%0d bresp=%b value=%h expected 1 00 0000beef",
               ok, resp, exit_value[63:32]);
    end
    tests_run++;
    if (exit_zero[1] !== 1'b0 || any_fail !== 1'b1) begin
      tests_failed++;
      $display("FAIL nonzero_fail: zero1=%b fail=%b expected 0 1", exit_zero[1], any_fail);
    end
    axi_write(20'h00024, 32'h0, 4'hF, resp, ok);
    tests_run++;
    if (resp !== 2'b00 || exit_value[63:32] !== 32'h0000_BEEF || exit_zero[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL sticky_second_write: bresp=%b value=%h zero1=%b expected 00 0000beef 0",
               resp, exit_value[63:32], exit_zero[1]);
    end
  endtask

  task automatic test_w_first();
    bus.bready = 1'b0;
    bus.wdata = 32'h7; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.wvalid = 1'b0;
    tests_run++;
    if (bus.wready !== 1'b0 || bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
      tests_failed++;
      $display("FAIL w_only_capture: wready=%b bvalid=%b awready=%b expected 0 0 1",
               bus.wready, bus.bvalid, bus.awready);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (exit_valid[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL w_only_no_effect: valid3=%b expected 0", exit_valid[3]);
    end
    bus.awaddr = 20'h00064; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    tests_run++;
    if (bus.bvalid !== 1'b1 || exit_valid[3] !== 1'b1 || exit_value[127:96] !== 32'h7) begin
      tests_failed++;
      $display("FAIL w_first_commit: bvalid=%b valid3=%b value=%h expected 1 1 00000007",
               bus.bvalid, exit_valid[3], exit_value[127:96]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin
        tests_failed++;
        $display("FAIL b_hold[%0d]: bvalid,bresp,awready,wready=%b expected 10000",
                 i, {bus.bvalid, bus.bresp, bus.awready, bus.wready});
      end
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    tests_run++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b_release: bvalid=%b awready=%b wready=%b expected 0 1 1",
               bus.bvalid, bus.awready, bus.wready);
    end
  endtask

  task automatic test_exit_ok_clear();
    logic [1:0] resp; bit ok;
    for (int c = 0; c < 4; c++) axi_write(20'h10 + 20'(c * 32), 32'h0, 4'hF, resp, ok);
    tests_run++;
    if (all_exited !== 1'b1 || exit_zero !== 4'b0101 || any_fail !== 1'b1) begin
      tests_failed++;
      $display("FAIL exit_ok_all: all=%b zero=%b fail=%b expected 1 0101 1",
               all_exited, exit_zero, any_fail);
    end
    axi_write(20'h00058, 32'h0, 4'hF, resp, ok);
    tests_run++;
    if (all_exited !== 1'b0 || exit_valid !== 4'b1011 || exit_zero !== 4'b0001) begin
      tests_failed++;
      $display("FAIL clear_ch2: all=%b valid=%b zero=%b expected 0 1011 0001",
               all_exited, exit_valid, exit_zero);
    end
  endtask

  task automatic test_reads();
    logic [31:0] data; logic [1:0] resp; bit ok;
    axi_read(20'h00020, data, resp, ok);
    tests_run++;
    if (!ok || data !== 32'h1 || resp !== 2'b00) begin
      tests_failed++;
      $display("FAIL read_status_ch1: on_time=%0d rdata=%h rresp=%b expected 1 00000001 00", ok, data, resp);
    end
    axi_read(20'h00000, data, resp, ok);
    tests_run++;
    if (data !== 32'h3 || resp !== 2'b00) begin
      tests_failed++;
      $display("FAIL read_status_ch0: rdata=%h rresp=%b expected 00000003 00", data, resp);
    end
    axi_read(20'h00028, data, resp, ok);
    tests_run++;
    if (data !== 32'h0000_BEEF || resp !== 2'b00) begin
      tests_failed++;
      $display("FAIL read_value_ch1: rdata=%h rresp=%b expected 0000beef 00", data, resp);
    end
    axi_read(20'h000A0, data, resp, ok);
    tests_run++;
    if (!ok || data !== 32'h0 || resp !== 2'b10) begin
      tests_failed++;
      $display("FAIL read_bad_channel: rdata=%h rresp=%b expected 00000000 10", data, resp);
    end
    axi_read(20'h0002C, data, resp, ok);
    tests_run++;
    if (data !== 32'h0 || resp !== 2'b00) begin
      tests_failed++;
      $display("FAIL read_unmapped_offset: rdata=%h rresp=%b expected 00000000 00", data, resp);
    end
  endtask

  task automatic test_boundary();
    logic [1:0] resp; bit ok;
    axi_write(20'h000A4, 32'h5, 4'hF, resp, ok);
    tests_run++;
    if (resp !== 2'b10 || exit_valid !== 4'b1011 || exit_value[63:32] !== 32'h0000_BEEF) begin
      tests_failed++;
      $display("FAIL write_bad_channel: bresp=%b valid=%b value1=%h expected 10 1011 0000beef",
               resp, exit_valid, exit_value[63:32]);
    end
    axi_write(20'h00044, 32'h1234, 4'h0, resp, ok);
    tests_run++;
    if (resp !== 2'b00 || exit_valid[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_strobe: bresp=%b valid2=%b expected 00 0", resp, exit_valid[2]);
    end
    axi_write(20'h00048, 32'h1234, 4'hF, resp, ok);
    tests_run++;
    if (resp !== 2'b00 || exit_valid[2] !== 1'b0 || exit_value[95:64] !== 32'h0) begin
      tests_failed++;
      $display("FAIL write_ro_value: bresp=%b valid2=%b value2=%h expected 00 0 00000000",
               resp, exit_valid[2], exit_value[95:64]);
    end
    axi_write(20'h00044, 32'h1234_5678, 4'b0101, resp, ok);
    tests_run++;
    if (exit_value[95:64] !== 32'h0034_0078 || exit_valid !== 4'b1111 || exit_zero[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL sparse_strobe: value2=%h valid=%b zero2=%b expected 00340078 1111 0",
               exit_value[95:64], exit_valid, exit_zero[2]);
    end
  endtask

  task automatic test_concurrent();
    bus.awaddr = 20'h00058; bus.awvalid = 1'b1;
    bus.wdata = 32'h0; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 20'h00048; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    tests_run++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0034_0078 || bus.bvalid !== 1'b1 ||
        exit_valid !== 4'b1011) begin
      tests_failed++;
      $display("FAIL read_during_write: rvalid=%b rdata=%h bvalid=%b valid=%b expected 1 00340078 1 1011",
               bus.rvalid, bus.rdata, bus.bvalid, exit_valid);
    end
    @(negedge clk);
    bus.bready = 1'b0; bus.rready = 1'b0;
    tests_run++;
    if (bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL concurrent_release: rvalid=%b bvalid=%b expected 0 0", bus.rvalid, bus.bvalid);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; bit ok;
    bus.awaddr = 20'h00050; bus.awvalid = 1'b1;
    bus.wdata = 32'h0; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tests_run++;
    if (bus.bvalid !== 1'b1 || exit_valid !== 4'b1111 || all_exited !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_pending: bvalid=%b valid=%b all=%b expected 1 1111 1",
               bus.bvalid, exit_valid, all_exited);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.bvalid !== 1'b0 || exit_valid !== 4'b0 || exit_zero !== 4'b0 || exit_value !== 128'h0 ||
        all_exited !== 1'b0 || any_fail !== 1'b0 || bus.awready !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: bvalid=%b valid=%b zero=%b all=%b fail=%b awready=%b value=%h",
               bus.bvalid, exit_valid, exit_zero, all_exited, any_fail, bus.awready, exit_value);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    axi_write(20'h00004, 32'h55, 4'hF, resp, ok);
    tests_run++;
    if (!ok || resp !== 2'b00 || exit_value[31:0] !== 32'h55 || exit_valid !== 4'b0001 ||
        any_fail !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_write: on_time=%0d bresp=%b value0=%h valid=%b fail=%b expected 1 00 00000055 0001 1",
               ok, resp, exit_value[31:0], exit_valid, any_fail);
    end
  endtask

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    test_reset();
    test_exit_zero();
    test_sticky();
    test_w_first();
    test_exit_ok_clear();
    test_reads();
    test_boundary();
    test_concurrent();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
